// File: rtl/fetch_sequencer_if.sv
// Handshake/bus bundle for fetch_sequencer: control inputs, memory port and fetched-instruction outputs.
// The mem_wait stall input exists only when MEM_WAIT_EN is defined.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned REG_WIDTH  = 8
);
    logic                  start;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_val;
    logic [REG_WIDTH-1:0]  mem_data_in;
    logic                  get_next;
`ifdef MEM_WAIT_EN
    logic                  mem_wait;
`endif
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [REG_WIDTH-1:0]  instruction_out;
    logic [REG_WIDTH-1:0]  operand_lo;
    logic [REG_WIDTH-1:0]  operand_hi;
    logic                  instruction_ready;
    logic                  illegal;
    logic                  busy;

    modport master (
`ifdef MEM_WAIT_EN
        output mem_wait,
`endif
        output start, pc_load, pc_load_val, mem_data_in, get_next,
        input  mem_addr, mem_rd, instruction_out, operand_lo, operand_hi,
        input  instruction_ready, illegal, busy
    );

    modport slave (
`ifdef MEM_WAIT_EN
        input  mem_wait,
`endif
        input  start, pc_load, pc_load_val, mem_data_in, get_next,
        output mem_addr, mem_rd, instruction_out, operand_lo, operand_hi,
        output instruction_ready, illegal, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches an opcode plus 0..2 operand bytes from a synchronous memory and holds them for the decoder.
// Define MEM_WAIT_EN to add the mem_wait stall input.
module fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned REG_WIDTH  = 8
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ISSUE_OP, CAP_OP, ISSUE_LO, CAP_LO, ISSUE_HI, CAP_HI, READY
    } state_t;

    state_t                r_state, w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [REG_WIDTH-1:0]  r_instr, w_instr_next;
    logic [REG_WIDTH-1:0]  r_op_lo, w_op_lo_next;
    logic [REG_WIDTH-1:0]  r_op_hi, w_op_hi_next;
    logic [1:0]            r_n, w_n_next, w_opc_n;
    logic                  r_illegal, w_illegal_next, w_opc_illegal;
    logic                  r_mem_rd, w_mem_rd_next;
    logic                  r_ready, w_ready_next;
    logic                  r_busy, w_busy_next;
    logic                  w_stall;

`ifdef MEM_WAIT_EN
    assign w_stall = bus.mem_wait && (r_state != IDLE) && (r_state != READY);
`else
    assign w_stall = 1'b0;
`endif

    // Operand count decoded straight from the opcode byte arriving in CAP_OP
    always_comb begin
        w_opc_n       = 2'd1;
        w_opc_illegal = 1'b0;
        if (bus.mem_data_in[1:0] == 2'b11) begin
            w_opc_n       = 2'd0;
            w_opc_illegal = 1'b1;
        end else if (bus.mem_data_in[4:2] inside {3'b011, 3'b110, 3'b111}) begin
            w_opc_n = 2'd2;
        end else if (bus.mem_data_in[4:2] == 3'b010 && bus.mem_data_in[1:0] == 2'b10) begin
            w_opc_n = 2'd0;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_pc_next      = r_pc;
        w_instr_next   = r_instr;
        w_op_lo_next   = r_op_lo;
        w_op_hi_next   = r_op_hi;
        w_n_next       = r_n;
        w_illegal_next = r_illegal;
        if (bus.pc_load) begin
            w_next_state   = IDLE;
            w_pc_next      = bus.pc_load_val;
            w_illegal_next = 1'b0;
        end else if (!w_stall) begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_next_state   = ISSUE_OP;
                        w_illegal_next = 1'b0;
                    end
                end
                ISSUE_OP: w_next_state = CAP_OP;
                CAP_OP: begin
                    w_instr_next   = bus.mem_data_in;
                    w_op_lo_next   = '0;
                    w_op_hi_next   = '0;
                    w_n_next       = w_opc_n;
                    w_illegal_next = w_opc_illegal;
                    w_pc_next      = r_pc + ADDR_WIDTH'(1);
                    w_next_state   = (w_opc_n == 2'd0) ? READY : ISSUE_LO;
                end
                ISSUE_LO: w_next_state = CAP_LO;
                CAP_LO: begin
                    w_op_lo_next = bus.mem_data_in;
                    w_pc_next    = r_pc + ADDR_WIDTH'(1);
                    w_next_state = (r_n == 2'd2) ? ISSUE_HI : READY;
                end
                ISSUE_HI: w_next_state = CAP_HI;
                CAP_HI: begin
                    w_op_hi_next = bus.mem_data_in;
                    w_pc_next    = r_pc + ADDR_WIDTH'(1);
                    w_next_state = READY;
                end
                READY: begin
                    if (bus.get_next) begin
                        w_next_state   = ISSUE_OP;
                        w_illegal_next = 1'b0;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
        // Status outputs are registered from the upcoming state
        w_mem_rd_next = (w_next_state == ISSUE_OP) || (w_next_state == ISSUE_LO) ||
                        (w_next_state == ISSUE_HI);
        w_ready_next  = (w_next_state == READY);
        w_busy_next   = (w_next_state != IDLE) && (w_next_state != READY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_instr   <= '0;
            r_op_lo   <= '0;
            r_op_hi   <= '0;
            r_n       <= '0;
            r_illegal <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_instr   <= w_instr_next;
            r_op_lo   <= w_op_lo_next;
            r_op_hi   <= w_op_hi_next;
            r_n       <= w_n_next;
            r_illegal <= w_illegal_next;
            r_mem_rd  <= w_mem_rd_next;
            r_ready   <= w_ready_next;
            r_busy    <= w_busy_next;
        end
    end

    assign bus.mem_addr          = r_pc;
    assign bus.mem_rd            = r_mem_rd;
    assign bus.instruction_out   = r_instr;
    assign bus.operand_lo        = r_op_lo;
    assign bus.operand_hi        = r_op_hi;
    assign bus.instruction_ready = r_ready;
    assign bus.illegal           = r_illegal;
    assign bus.busy              = r_busy;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a synchronous byte memory model.
// Stall coverage is compiled in when MEM_WAIT_EN is defined.
module tb_fetch_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   lat;

    logic [7:0] mem [0:65535];
    logic [7:0] r_mem_q;

    fetch_sequencer_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

    fetch_sequencer #(.ADDR_WIDTH(16), .REG_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous read: data valid the cycle after the address is strobed
    always @(posedge clk) begin
        if (bus.mem_rd) r_mem_q <= mem[bus.mem_addr];
    end
    assign bus.mem_data_in = r_mem_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start (or get_next) for the sampling edge, then counts edges until ready
    task automatic do_fetch(input bit use_get_next, output int latency);
        bit done;
        if (use_get_next) bus.get_next = 1'b1;
        else              bus.start    = 1'b1;
        tick();
        bus.get_next = 1'b0;
        bus.start    = 1'b0;
        latency = 0;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            latency++;
            if (bus.instruction_ready) done = 1'b1;
        end
        if (!done) latency = -1;
    endtask

    task automatic load_pc(input logic [15:0] val);
        bus.pc_load     = 1'b1;
        bus.pc_load_val = val;
        tick();
        bus.pc_load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h05;
        mem[16'h0300] = 8'hAD; mem[16'h0301] = 8'h34; mem[16'h0302] = 8'h12;
        mem[16'h0303] = 8'h0A; mem[16'h0304] = 8'h03;
        mem[16'h0305] = 8'hA9; mem[16'h0306] = 8'h77;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h42;
        mem[16'h0400] = 8'hAD; mem[16'h0401] = 8'h11; mem[16'h0402] = 8'h22;
        mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h5A;

        bus.start       = 1'b0;
        bus.pc_load     = 1'b0;
        bus.pc_load_val = 16'h0000;
        bus.get_next    = 1'b0;
`ifdef MEM_WAIT_EN
        bus.mem_wait    = 1'b0;
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_addr",  32'(bus.mem_addr), 32'h0);
        check("rst_rd",    32'(bus.mem_rd), 32'h0);
        check("rst_ready", 32'(bus.instruction_ready), 32'h0);
        check("rst_busy",  32'(bus.busy), 32'h0);
        check("rst_ill",   32'(bus.illegal), 32'h0);
        check("rst_instr", 32'(bus.instruction_out), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // LDA #imm: one operand
        load_pc(16'h0200);
        check("ld_addr", 32'(bus.mem_addr), 32'h0200);
        check("ld_busy", 32'(bus.busy), 32'h0);
        do_fetch(1'b0, lat);
        check("a9_lat",   32'(lat), 32'd4);
        check("a9_instr", 32'(bus.instruction_out), 32'hA9);
        check("a9_lo",    32'(bus.operand_lo), 32'h05);
        check("a9_hi",    32'(bus.operand_hi), 32'h00);
        check("a9_pc",    32'(bus.mem_addr), 32'h0202);
        check("a9_busy",  32'(bus.busy), 32'h0);
        repeat (3) tick();
        check("a9_hold_rdy",   32'(bus.instruction_ready), 32'h1);
        check("a9_hold_instr", 32'(bus.instruction_out), 32'hA9);

        // LDA abs: two operands
        load_pc(16'h0300);
        check("ld_clr_rdy", 32'(bus.instruction_ready), 32'h0);
        do_fetch(1'b0, lat);
        check("ad_lat", 32'(lat), 32'd6);
        check("ad_lo",  32'(bus.operand_lo), 32'h34);
        check("ad_hi",  32'(bus.operand_hi), 32'h12);
        check("ad_pc",  32'(bus.mem_addr), 32'h0303);

        // ASL A, then illegal 03, then a legal fetch clears illegal
        do_fetch(1'b1, lat);
        check("0a_lat",   32'(lat), 32'd2);
        check("0a_instr", 32'(bus.instruction_out), 32'h0A);
        check("0a_lo",    32'(bus.operand_lo), 32'h00);
        check("0a_hi",    32'(bus.operand_hi), 32'h00);
        check("0a_ill",   32'(bus.illegal), 32'h0);
        do_fetch(1'b1, lat);
        check("03_lat",   32'(lat), 32'd2);
        check("03_ill",   32'(bus.illegal), 32'h1);
        check("03_pc",    32'(bus.mem_addr), 32'h0305);
        do_fetch(1'b1, lat);
        check("nx_lat", 32'(lat), 32'd4);
        check("nx_ill", 32'(bus.illegal), 32'h0);
        check("nx_lo",  32'(bus.operand_lo), 32'h77);

        // get_next ignored while IDLE
        load_pc(16'hFFFF);
        bus.get_next = 1'b1;
        tick();
        bus.get_next = 1'b0;
        check("gn_idle_busy", 32'(bus.busy), 32'h0);
        check("gn_idle_rd",   32'(bus.mem_rd), 32'h0);
        check("gn_idle_pc",   32'(bus.mem_addr), 32'hFFFF);

        // pc wrap: opcode at FFFF, operand at 0000
        do_fetch(1'b0, lat);
        check("wr_lat", 32'(lat), 32'd4);
        check("wr_lo",  32'(bus.operand_lo), 32'h42);
        check("wr_pc",  32'(bus.mem_addr), 32'h0001);

        // pc_load aborts a fetch in CAP_LO
        load_pc(16'h0400);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("cl_busy", 32'(bus.busy), 32'h1);
        check("cl_rd",   32'(bus.mem_rd), 32'h0);
        check("cl_pc",   32'(bus.mem_addr), 32'h0401);
        load_pc(16'h0500);
        check("ab_busy", 32'(bus.busy), 32'h0);
        check("ab_rdy",  32'(bus.instruction_ready), 32'h0);
        check("ab_pc",   32'(bus.mem_addr), 32'h0500);
        repeat (2) tick();
        check("ab_rdy2", 32'(bus.instruction_ready), 32'h0);

        // Asynchronous reset mid ISSUE_HI
        load_pc(16'h0400);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("ih_rd", 32'(bus.mem_rd), 32'h1);
        check("ih_pc", 32'(bus.mem_addr), 32'h0402);
        #2 reset = 1'b1;
        #1;
        check("ar_pc",    32'(bus.mem_addr), 32'h0);
        check("ar_rd",    32'(bus.mem_rd), 32'h0);
        check("ar_busy",  32'(bus.busy), 32'h0);
        check("ar_instr", 32'(bus.instruction_out), 32'h0);
        check("ar_lo",    32'(bus.operand_lo), 32'h0);
        check("ar_hi",    32'(bus.operand_hi), 32'h0);
        tick();
        reset = 1'b0;
        tick();

`ifdef MEM_WAIT_EN
        // Three stall cycles in ISSUE_LO stretch latency from 4 to 7
        load_pc(16'h0600);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mw_rd", 32'(bus.mem_rd), 32'h1);
            check("mw_pc", 32'(bus.mem_addr), 32'h0601);
        end
        bus.mem_wait = 1'b0;
        lat = 5;
        tick();
        check("mw_notrdy", 32'(bus.instruction_ready), 32'h0);
        lat++;
        tick();
        lat++;
        check("mw_rdy", 32'(bus.instruction_ready), 32'h1);
        check("mw_lat", 32'(lat), 32'd7);
        check("mw_lo",  32'(bus.operand_lo), 32'h5A);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have the parameter ADDR_WIDTH, default 16, meaning the program counter and memory address width.
REQ-002 The block SHALL have the parameter REG_WIDTH, default 8, meaning the opcode, operand and memory data width.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have the port start, input, 1 bit: begin fetching at pc, sampled only in IDLE.
REQ-007 The block SHALL have the port pc_load, input, 1 bit: load pc from pc_load_val.
REQ-008 The block SHALL have the port pc_load_val, input, ADDR_WIDTH bits: new pc value.
REQ-009 The block SHALL have the port mem_data_in, input, REG_WIDTH bits: synchronous memory read data, valid the cycle after the address is issued.
REQ-010 The block SHALL have the port get_next, input, 1 bit: decoder acknowledge of the held instruction.
REQ-011 The block SHALL have the port mem_addr, output, ADDR_WIDTH bits: read address, equal to pc.
REQ-012 The block SHALL have the port mem_rd, output, 1 bit: read strobe.
REQ-013 The block SHALL have the ports instruction_out, operand_lo and operand_hi, output, REG_WIDTH bits each: the fetched bytes.
REQ-014 The block SHALL have the ports instruction_ready, illegal and busy, output, 1 bit each.

Function
REQ-015 The block SHALL implement the states IDLE, ISSUE_OP, CAP_OP, ISSUE_LO, CAP_LO, ISSUE_HI, CAP_HI and READY.
REQ-016 mem_rd SHALL be 1 only in the ISSUE_* states, and mem_addr SHALL equal pc in every state.
REQ-017 In IDLE, start=1 SHALL move the block to ISSUE_OP.
REQ-018 Each ISSUE_* state SHALL advance unconditionally to its CAP_* state.
REQ-019 Each CAP_* state SHALL capture mem_data_in into its byte register and increment pc by 1 modulo 2^ADDR_WIDTH, so 16'hFFFF wraps to 16'h0000.
REQ-020 At CAP_OP, the operand count n SHALL be taken from the captured opcode byte:
- bits[1:0]=2'b11: n=0 and illegal=1;
- bits[4:2] in {011, 110, 111}: n=2;
- bits[4:2]=010 with bits[1:0]=2'b10 (accumulator/implied): n=0;
- all other cases: n=1.
REQ-021 When n=0, CAP_OP SHALL go to READY, and operand_lo and operand_hi SHALL be 0.
REQ-022 When n>=1, CAP_OP SHALL go to ISSUE_LO.
REQ-023 CAP_LO SHALL go to ISSUE_HI when n=2, and to READY otherwise with operand_hi=0.
REQ-024 CAP_HI SHALL go to READY.
REQ-025 instruction_ready SHALL be 1 only in READY, and the outputs SHALL hold stable there until get_next=1.
REQ-026 get_next=1 in READY SHALL move the block to ISSUE_OP at the updated pc; the next fetch SHALL clear illegal.
REQ-027 get_next SHALL be ignored outside READY.
REQ-028 Latency from the edge that samples start (or get_next) to instruction_ready=1 SHALL be 2*(1+n) cycles.
REQ-029 pc_load=1 in any state SHALL load pc, clear instruction_ready and illegal, and force IDLE, aborting any fetch in progress; pc_load SHALL take priority over get_next and start in the same cycle.
REQ-030 busy SHALL be 1 in every state other than IDLE and READY.

Reset
REQ-031 Asserting reset SHALL immediately set:
- state to IDLE;
- pc, instruction_out, operand_lo and operand_hi to 0;
- mem_rd, instruction_ready, illegal and busy to 0.
REQ-032 Deassertion of reset SHALL take effect at the next rising edge of clk, and reset SHALL apply from any state, including mid-fetch.

Configuration
REQ-033 With MEM_WAIT_EN defined, the block SHALL have the additional port mem_wait, input, 1 bit.
REQ-034 With MEM_WAIT_EN defined, mem_wait=1 SHALL freeze the state and pc, hold mem_rd and mem_addr, and ignore mem_data_in; pc_load and reset SHALL still act.
REQ-035 Without MEM_WAIT_EN, the mem_wait port SHALL be absent and the block SHALL never stall.

Verification
REQ-036 The bench SHALL cover: reset, pc_load 16'h0200, start, memory 0200=A9 0201=05 -> instruction_ready after 4 cycles, instruction_out=A9, operand_lo=05, operand_hi=00, pc=0202.
REQ-037 The bench SHALL cover: opcode AD at 0300, operands 34 12 -> ready after 6 cycles, operand_lo=34, operand_hi=12, pc=0303.
REQ-038 The bench SHALL cover: opcode 0A (ASL A) -> ready after 2 cycles, both operands 00; opcode 03 -> illegal=1, n=0.
REQ-039 The bench SHALL cover: pc_load FFFF, 2-byte instruction -> operand fetched from FFFF?no; opcode at FFFF, operand at 0000, final pc=0001.
REQ-040 The bench SHALL cover: pc_load asserted in CAP_LO -> IDLE next cycle, instruction_ready stays 0; reset asserted mid-ISSUE_HI -> all outputs 0 with no clock edge.
REQ-041 The bench SHALL cover, with MEM_WAIT_EN: mem_wait held 3 cycles in ISSUE_LO -> latency grows by exactly 3 and operand_lo is correct.
